// File: rtl/cp0_unit.sv
// cp0_unit -- Coprocessor-0 exception controller beside the M stage.
//
// Merges the M-stage exception code with masked hardware interrupts and
// raises req, which flushes every pipeline register toward the handler.
// Holds SR (12), Cause (13), EPC (14) and PRId (15) for mfc0/mtc0/eret.
//
// Optional feature macro: CP0_BADVADDR_EN adds badvaddr_in and a BadVAddr
// register (8) that captures the faulting address on AdEL/AdES.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high
//   en           mtc0 write strobe
//   cp0_addr     CP0 register number (read and write)
//   cp0_wdata    mtc0 data
//   cp0_rdata    mfc0 data, combinational on cp0_addr, registered values only
//   vpc          PC of the M instruction
//   bd_in        M instruction sits in a branch delay slot
//   exc_code_in  exception code of the M instruction, 0 = none
//   hw_int       level-sensitive hardware interrupt lines
//   eret         eret executing in M
//   req          take exception/interrupt now (combinational)
//   epc_out      return address for eret, forwards a same-cycle EPC write
//   badvaddr_in  faulting address (CP0_BADVADDR_EN only)
module cp0_unit #(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] badvaddr_in,
`endif
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // SR fields
  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  // Cause fields
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;

  // EXL masks both sources: only one exception is taken until eret.
  assign w_int_req = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc_req = (exc_code_in != 5'd0) & ~r_sr_exl;
  assign w_req     = (w_int_req | w_exc_req) & ~reset;
  assign req       = w_req;

  assign w_wr_sr  = en && (cp0_addr == ADDR_SR);
  assign w_wr_epc = en && (cp0_addr == ADDR_EPC);

  // Forward a same-cycle EPC write so an mtc0 followed by eret returns to the
  // new address without a stall.
  assign epc_out = w_wr_epc ? cp0_wdata : r_epc;

`ifdef CP0_BADVADDR_EN
  logic [31:0] r_badvaddr;
  logic        w_addr_err;

  assign w_addr_err = (exc_code_in == 5'd4) || (exc_code_in == 5'd5);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_badvaddr <= 32'd0;
    end else if (w_req && !w_int_req && w_addr_err) begin
      r_badvaddr <= badvaddr_in;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'd0;
    end else begin
      r_cause_ip <= hw_int;
      if (w_req) begin
        // Taking the exception discards any same-cycle mtc0 or eret.
        r_sr_exl    <= 1'b1;
        r_cause_exc <= w_int_req ? 5'd0 : exc_code_in;
        r_cause_bd  <= bd_in;
        r_epc       <= bd_in ? (vpc - 32'd4) : vpc;
      end else begin
        if (w_wr_sr) begin
          r_sr_im  <= cp0_wdata[15:10];
          r_sr_exl <= cp0_wdata[1];
          r_sr_ie  <= cp0_wdata[0];
        end
        if (w_wr_epc) begin
          r_epc <= cp0_wdata;
        end
        // Placed after the SR write so eret wins on EXL when both occur.
        if (eret) begin
          r_sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_SR:    cp0_rdata = {16'd0, r_sr_im, 8'd0, r_sr_exl, r_sr_ie};
      ADDR_CAUSE: cp0_rdata = {r_cause_bd, 15'd0, r_cause_ip, 3'd0,
                               r_cause_exc, 2'd0};
      ADDR_EPC:   cp0_rdata = r_epc;
      ADDR_PRID:  cp0_rdata = PRID;
`ifdef CP0_BADVADDR_EN
      ADDR_BADVADDR: cp0_rdata = r_badvaddr;
`endif
      default:    cp0_rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed cases from the feature list, then randomized
// traffic checked every cycle against a word-level model of the registers.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0000_0007;

  // clock / reset block
  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic [31:0] badvaddr_in;
  logic        req;
  logic [31:0] epc_out;

  always #10 clk = ~clk;

  cp0_unit #(.PRID(PRID)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .cp0_rdata   (cp0_rdata),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .eret        (eret),
`ifdef CP0_BADVADDR_EN
    .badvaddr_in (badvaddr_in),
`endif
    .req         (req),
    .epc_out     (epc_out)
  );

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: whole 32-bit register images
  logic [31:0] m_sr, m_cause, m_epc, m_bva;

  function automatic logic [31:0] model_req();
    logic int_r, exc_r;
    int_r = (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    exc_r = (exc_code_in != 0) && !m_sr[1];
    return {31'd0, (int_r || exc_r) && !reset};
  endfunction

  function automatic logic [31:0] model_rdata(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return PRID;
`ifdef CP0_BADVADDR_EN
      5'd8:  return m_bva;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_epc_out();
    return (en && cp0_addr == 5'd14) ? cp0_wdata : m_epc;
  endfunction

  task automatic model_edge();
    logic is_int;
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
      return;
    end
    is_int = (|(hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    if (model_req() != 0) begin
      m_sr    = m_sr | 32'h2;
      m_cause = ({31'd0, bd_in} << 31) | ({26'd0, hw_int} << 10)
              | ((is_int ? 32'd0 : {27'd0, exc_code_in}) << 2);
      m_epc   = bd_in ? vpc - 4 : vpc;
      if (!is_int && (exc_code_in == 4 || exc_code_in == 5)) m_bva = badvaddr_in;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
      if (en && cp0_addr == 12) m_sr = cp0_wdata & 32'h0000_FC03;
      if (en && cp0_addr == 14) m_epc = cp0_wdata;
      if (eret) m_sr = m_sr & ~32'h2;
    end
  endtask

  // driver tasks
  task automatic set_idle();
    reset = 0; en = 0; eret = 0; exc_code_in = 0; hw_int = 0; bd_in = 0;
    cp0_wdata = 0; badvaddr_in = 0;
  endtask

  // Inputs are already applied; check combinational outputs before the
  // edge, advance the model, then cross the edge.
  task automatic drive_cycle();
    @(negedge clk);
    exp_q.push_back(model_req());
    exp_q.push_back(model_epc_out());
    exp_q.push_back(model_rdata(cp0_addr));
    check_val("req", {31'd0, req}, exp_q.pop_front());
    check_val("epc_out", epc_out, exp_q.pop_front());
    check_val("rdata", cp0_rdata, exp_q.pop_front());
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_expect(input string tag, input logic [4:0] a,
                           input logic [31:0] exp);
    cp0_addr = a;
    #1;
    check_val(tag, cp0_rdata, exp);
  endtask

  task automatic req_expect(input string tag, input logic exp);
    #1;
    check_val(tag, {31'd0, req}, {31'd0, exp});
  endtask

  logic [4:0] addr_tab [8] = '{5'd8, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3, 5'd31};

  initial begin
    set_idle();
    reset = 1; cp0_addr = 12; vpc = 0;
    m_sr = 0; m_cause = 0; m_epc = 0; m_bva = 0;
    @(posedge clk); #1;

    // reset: req low even with a pending exception code and interrupts
    reset = 1; exc_code_in = 10; hw_int = 6'h3f;
    req_expect("reset_req", 1'b0);
    drive_cycle();
    drive_cycle();
    set_idle();
    rd_expect("rst_sr", 12, 32'h0);
    rd_expect("rst_cause", 13, 32'h0);
    rd_expect("rst_epc", 14, 32'h0);
    rd_expect("rst_prid", 15, PRID);
    check_val("rst_epc_out", epc_out, 32'h0);

    // interrupt path
    en = 1; cp0_addr = 12; cp0_wdata = 32'h0000_0401;
    drive_cycle();
    set_idle(); hw_int = 6'b000001; vpc = 32'h0000_1000;
    req_expect("int_req", 1'b1);
    drive_cycle();
    rd_expect("int_cause", 13, 32'h0000_0400);
    rd_expect("int_sr", 12, 32'h0000_0403);
    rd_expect("int_epc", 14, 32'h0000_1000);
    check_val("int_req_drop", {31'd0, req}, 32'h0);
    hw_int = 0; eret = 1;
    drive_cycle();
    set_idle();
    rd_expect("eret_sr", 12, 32'h0000_0401);

    // exception in a delay slot, then a masked second exception
    exc_code_in = 10; bd_in = 1; vpc = 32'h0000_3008;
    req_expect("exc_req", 1'b1);
    drive_cycle();
    set_idle();
    rd_expect("bd_epc", 14, 32'h0000_3004);
    rd_expect("bd_cause", 13, 32'h8000_0028);
    exc_code_in = 12;
    req_expect("exc_masked", 1'b0);
    drive_cycle();

    // EPC write forwarding, then eret
    set_idle(); en = 1; cp0_addr = 14; cp0_wdata = 32'h0000_3100;
    #1;
    check_val("epc_fwd", epc_out, 32'h0000_3100);
    drive_cycle();
    set_idle(); eret = 1;
    drive_cycle();
    set_idle();
    rd_expect("eret_exl", 12, 32'h0000_0401);
    rd_expect("epc_wr", 14, 32'h0000_3100);

    // SR write loses to a same-cycle exception
    en = 1; cp0_addr = 12; cp0_wdata = 32'h0000_FC00; exc_code_in = 8;
    drive_cycle();
    set_idle();
    rd_expect("wr_vs_exc", 12, 32'h0000_0403);
    eret = 1;
    drive_cycle();
    // eret loses to a same-cycle exception
    set_idle(); eret = 1; exc_code_in = 8;
    drive_cycle();
    set_idle();
    rd_expect("eret_vs_exc", 12, 32'h0000_0403);

    // SR write and eret together: eret clears the written EXL
    en = 1; cp0_addr = 12; cp0_wdata = 32'h0000_0803; eret = 1;
    drive_cycle();
    set_idle();
    rd_expect("wr_and_eret", 12, 32'h0000_0801);

`ifdef CP0_BADVADDR_EN
    exc_code_in = 4; badvaddr_in = 32'h0000_0003;
    drive_cycle();
    set_idle();
    rd_expect("bva_adel", 8, 32'h0000_0003);
    eret = 1;
    drive_cycle();
    set_idle(); exc_code_in = 10; badvaddr_in = 32'h0000_0055;
    drive_cycle();
    set_idle();
    rd_expect("bva_keep", 8, 32'h0000_0003);
    eret = 1;
    drive_cycle();
    set_idle();
`else
    rd_expect("addr8_zero", 8, 32'h0);
`endif

    // reset in the middle of a handler
    exc_code_in = 9;
    drive_cycle();
    set_idle(); reset = 1;
    drive_cycle();
    set_idle();
    rd_expect("mid_rst_sr", 12, 32'h0);
    rd_expect("mid_rst_cause", 13, 32'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      hw_int      = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      exc_code_in = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) :
                    ($urandom_range(0, 19) == 0) ? 5'($urandom_range(4, 5)) : 5'd0;
      bd_in       = 1'($urandom_range(0, 1));
      vpc         = $urandom & 32'hFFFF_FFFC;
      en          = ($urandom_range(0, 2) == 0);
      cp0_addr    = addr_tab[$urandom_range(0, 7)];
      cp0_wdata   = $urandom;
      eret        = ($urandom_range(0, 5) == 0);
      badvaddr_in = $urandom;
      drive_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
